// File: rtl/ddr_refresh_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ddr_refresh_ctrl
// Description : DDR auto-refresh scheduler. Generates one refresh request per
//               tREFI interval, allows up to MAX_PENDING refreshes to be
//               postponed, issues a one-cycle AUTO REFRESH pulse on grant and
//               holds a tRFC busy window afterwards.
//               Optional feature macro: REF_OVERFLOW_FLAG_EN adds the sticky
//               ref_overflow error output.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_refresh_ctrl #(
  parameter int TREFI_CYCLES = 1040,
  parameter int TRFC_CYCLES  = 10,
  parameter int MAX_PENDING  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_done,
  input  logic       ref_grant,
  output logic       ref_req,
  output logic       ref_urgent,
  output logic       ref_cmd,
  output logic       ref_busy,
  output logic [3:0] pending_cnt
`ifdef REF_OVERFLOW_FLAG_EN
  ,
  output logic       ref_overflow
`endif
);

  localparam int c_INT_W = $clog2(TREFI_CYCLES + 1);
  localparam int c_RFC_W = $clog2(TRFC_CYCLES + 1);

  localparam logic [c_INT_W-1:0] c_INT_LAST  = c_INT_W'(TREFI_CYCLES - 1);
  // Entering RUN already accounts for the cycle in which init_done was seen.
  localparam logic [c_INT_W-1:0] c_INT_START = (TREFI_CYCLES > 1) ? c_INT_W'(1) : c_INT_W'(0);
  localparam logic [c_RFC_W-1:0] c_RFC_LAST  = c_RFC_W'(TRFC_CYCLES);
  localparam logic [c_RFC_W-1:0] c_RFC_ONE   = c_RFC_W'(1);
  localparam logic [3:0]         c_MAX       = 4'(MAX_PENDING);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RUN      = 2'd1,
    ST_ISSUE    = 2'd2,
    ST_WAIT_RFC = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_INT_W-1:0]   r_int;
  logic [c_INT_W-1:0]   w_int_next;
  logic [c_RFC_W-1:0]   r_rfc;
  logic [c_RFC_W-1:0]   w_rfc_next;
  logic [3:0]           r_pend;
  logic [3:0]           w_pend_next;
  logic                 w_tick;
  logic                 w_dec;
  logic                 w_ovf;
  logic                 r_ref_req;
  logic                 r_ref_urgent;
  logic                 r_ref_cmd;
  logic                 r_ref_busy;

  // Next-state, interval counter, tRFC counter and pending-count logic.
  always_comb begin
    w_state_next = r_state;
    w_int_next   = r_int;
    w_rfc_next   = r_rfc;
    w_pend_next  = r_pend;
    w_dec        = 1'b0;
    w_ovf        = 1'b0;
    w_tick       = (r_state != ST_DISABLED) && (r_int == c_INT_LAST);

    if (!init_done) begin
      // Losing init_done abandons everything, including a tRFC window.
      w_state_next = ST_DISABLED;
      w_int_next   = '0;
      w_rfc_next   = '0;
      w_pend_next  = '0;
    end else begin
      if (r_state == ST_DISABLED) begin
        w_int_next = c_INT_START;
      end else begin
        w_int_next = w_tick ? '0 : r_int + c_INT_W'(1);
      end

      case (r_state)
        ST_DISABLED: begin
          w_state_next = ST_RUN;
        end
        ST_RUN: begin
          // ref_req already implies a nonzero pending count.
          if (r_ref_req && ref_grant) begin
            w_state_next = ST_ISSUE;
            w_rfc_next   = c_RFC_ONE;
            w_dec        = 1'b1;
          end
        end
        ST_ISSUE, ST_WAIT_RFC: begin
          if (r_rfc >= c_RFC_LAST) begin
            w_state_next = ST_RUN;
            w_rfc_next   = '0;
          end else begin
            w_state_next = ST_WAIT_RFC;
            w_rfc_next   = r_rfc + c_RFC_ONE;
          end
        end
        default: begin
          w_state_next = ST_DISABLED;
        end
      endcase

      // A tick and a grant together cancel out and never count as overflow.
      if (w_tick && !w_dec) begin
        if (r_pend == c_MAX) begin
          w_ovf = 1'b1;
        end else begin
          w_pend_next = r_pend + 4'd1;
        end
      end else if (w_dec && !w_tick && (r_pend != 4'd0)) begin
        w_pend_next = r_pend - 4'd1;
      end
    end
  end

  // State register and outputs registered from next-state values so they
  // line up with the cycle in which the state they describe is current.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_DISABLED;
      r_int        <= '0;
      r_rfc        <= '0;
      r_pend       <= '0;
      r_ref_req    <= 1'b0;
      r_ref_urgent <= 1'b0;
      r_ref_cmd    <= 1'b0;
      r_ref_busy   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_int        <= w_int_next;
      r_rfc        <= w_rfc_next;
      r_pend       <= w_pend_next;
      r_ref_req    <= (w_state_next == ST_RUN) && (w_pend_next != 4'd0);
      r_ref_urgent <= (w_pend_next == c_MAX);
      r_ref_cmd    <= (w_state_next == ST_ISSUE);
      r_ref_busy   <= (w_state_next == ST_ISSUE) || (w_state_next == ST_WAIT_RFC);
    end
  end

`ifdef REF_OVERFLOW_FLAG_EN
  logic r_ovf;

  // Sticky overflow flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_ovf) begin
      r_ovf <= 1'b1;
    end
  end

  assign ref_overflow = r_ovf;
`else
  // Without the flag, overflowing ticks are silently dropped.
  logic w_ovf_unused;
  assign w_ovf_unused = w_ovf;
`endif

  assign ref_req     = r_ref_req;
  assign ref_urgent  = r_ref_urgent;
  assign ref_cmd     = r_ref_cmd;
  assign ref_busy    = r_ref_busy;
  assign pending_cnt = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_ddr_refresh_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_refresh_ctrl
// Description : Directed self-checking bench for ddr_refresh_ctrl (default
//               parameters). Inputs change and outputs are observed on the
//               falling edge; "cycle k" is the clock period following rising
//               edge k, counted from the cycle init_done is first driven high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_refresh_ctrl;

  logic       clk;
  logic       rst;
  logic       init_done;
  logic       ref_grant;
  logic       ref_req;
  logic       ref_urgent;
  logic       ref_cmd;
  logic       ref_busy;
  logic [3:0] pending_cnt;
`ifdef REF_OVERFLOW_FLAG_EN
  logic       ref_overflow;
`endif

  int n_assert;
  int n_fail;
  int cyc;
  int base;

  ddr_refresh_ctrl #(
    .TREFI_CYCLES (1040),
    .TRFC_CYCLES  (10),
    .MAX_PENDING  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .init_done    (init_done),
    .ref_grant    (ref_grant),
    .ref_req      (ref_req),
    .ref_urgent   (ref_urgent),
    .ref_cmd      (ref_cmd),
    .ref_busy     (ref_busy),
    .pending_cnt  (pending_cnt)
`ifdef REF_OVERFLOW_FLAG_EN
    ,
    .ref_overflow (ref_overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req"},    32'(ref_req),     32'd0);
    chk({tag, ".urgent"}, 32'(ref_urgent),  32'd0);
    chk({tag, ".cmd"},    32'(ref_cmd),     32'd0);
    chk({tag, ".busy"},   32'(ref_busy),    32'd0);
    chk({tag, ".pend"},   32'(pending_cnt), 32'd0);
`ifdef REF_OVERFLOW_FLAG_EN
    chk({tag, ".ovf"},    32'(ref_overflow), 32'd0);
`endif
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    cyc       = 0;
    rst       = 1'b1;
    init_done = 1'b0;
    ref_grant = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");

    // ---- Run 1: no grants, count up to saturation and overflow ----
    rst       = 1'b0;
    init_done = 1'b1;
    cyc       = 0;
    step();
    chk("r1.c1.req", 32'(ref_req), 32'd0);
    goto(1039);
    chk("r1.c1039.req",  32'(ref_req),     32'd0);
    chk("r1.c1039.pend", 32'(pending_cnt), 32'd0);
    goto(1040);
    chk("r1.c1040.req",    32'(ref_req),     32'd1);
    chk("r1.c1040.pend",   32'(pending_cnt), 32'd1);
    chk("r1.c1040.urgent", 32'(ref_urgent),  32'd0);
    goto(2079);
    chk("r1.c2079.pend", 32'(pending_cnt), 32'd1);
    goto(2080);
    chk("r1.c2080.pend", 32'(pending_cnt), 32'd2);
    goto(8319);
    chk("r1.c8319.pend",   32'(pending_cnt), 32'd7);
    chk("r1.c8319.urgent", 32'(ref_urgent),  32'd0);
    goto(8320);
    chk("r1.c8320.pend",   32'(pending_cnt), 32'd8);
    chk("r1.c8320.urgent", 32'(ref_urgent),  32'd1);
    chk("r1.c8320.req",    32'(ref_req),     32'd1);
`ifdef REF_OVERFLOW_FLAG_EN
    goto(9359);
    chk("r1.c9359.ovf", 32'(ref_overflow), 32'd0);
`endif
    goto(9360);
    chk("r1.c9360.pend",   32'(pending_cnt), 32'd8);
    chk("r1.c9360.urgent", 32'(ref_urgent),  32'd1);
`ifdef REF_OVERFLOW_FLAG_EN
    chk("r1.c9360.ovf", 32'(ref_overflow), 32'd1);
`endif

    // ---- Reset coincident with a grant ----
    goto(9400);
    chk("r1.c9400.req", 32'(ref_req), 32'd1);
    rst       = 1'b1;
    ref_grant = 1'b1;
    step();
    ref_grant = 1'b0;
    init_done = 1'b0;
    chk_all_zero("rstgrant");
    step();
    chk("rstgrant.cmd2", 32'(ref_cmd), 32'd0);

    // ---- Run 2: grant timing, then init_done drop during WAIT_RFC ----
    rst       = 1'b0;
    init_done = 1'b1;
    cyc       = 0;
    goto(1040);
    chk("r2.c1040.pend", 32'(pending_cnt), 32'd1);
    goto(1100);
    ref_grant = 1'b1;
    step();
    ref_grant = 1'b0;
    chk("gr.n1.cmd",  32'(ref_cmd),     32'd1);
    chk("gr.n1.busy", 32'(ref_busy),    32'd1);
    chk("gr.n1.req",  32'(ref_req),     32'd0);
    chk("gr.n1.pend", 32'(pending_cnt), 32'd0);
    for (int k = 2; k <= 10; k++) begin
      step();
      chk("gr.wait.cmd",  32'(ref_cmd),  32'd0);
      chk("gr.wait.busy", 32'(ref_busy), 32'd1);
      chk("gr.wait.req",  32'(ref_req),  32'd0);
    end
    step();
    chk("gr.n11.busy", 32'(ref_busy), 32'd0);
    chk("gr.n11.cmd",  32'(ref_cmd),  32'd0);
    chk("gr.n11.req",  32'(ref_req),  32'd0);
    goto(2080);
    chk("r2.c2080.pend", 32'(pending_cnt), 32'd1);
    chk("r2.c2080.req",  32'(ref_req),     32'd1);
    goto(3120);
    chk("r2.c3120.pend", 32'(pending_cnt), 32'd2);
    goto(3130);
    ref_grant = 1'b1;
    step();
    ref_grant = 1'b0;
    chk("r2.c3131.pend", 32'(pending_cnt), 32'd1);
    chk("r2.c3131.cmd",  32'(ref_cmd),     32'd1);
    goto(3135);
    chk("r2.c3135.busy", 32'(ref_busy), 32'd1);
    init_done = 1'b0;
    step();
    chk("drop.busy", 32'(ref_busy),    32'd0);
    chk("drop.pend", 32'(pending_cnt), 32'd0);
    chk("drop.req",  32'(ref_req),     32'd0);
    chk("drop.cmd",  32'(ref_cmd),     32'd0);
    goto(3140);
    init_done = 1'b1;
    base      = 3140;
    goto(base + 1039);
    chk("reinit.req_early", 32'(ref_req), 32'd0);
    goto(base + 1040);
    chk("reinit.req",  32'(ref_req),     32'd1);
    chk("reinit.pend", 32'(pending_cnt), 32'd1);

    // ---- Run 3: grant coincident with a tick at saturation ----
    rst       = 1'b1;
    init_done = 1'b0;
    step();
    step();
    rst       = 1'b0;
    init_done = 1'b1;
    cyc       = 0;
    goto(8320);
    chk("r3.c8320.pend", 32'(pending_cnt), 32'd8);
    goto(9359);
    ref_grant = 1'b1;
    step();
    ref_grant = 1'b0;
    chk("coin.pend",   32'(pending_cnt), 32'd8);
    chk("coin.cmd",    32'(ref_cmd),     32'd1);
    chk("coin.urgent", 32'(ref_urgent),  32'd1);
`ifdef REF_OVERFLOW_FLAG_EN
    chk("coin.ovf", 32'(ref_overflow), 32'd0);
`endif
    goto(9370);
    chk("coin.n11.busy", 32'(ref_busy),    32'd0);
    chk("coin.n11.req",  32'(ref_req),     32'd1);
    chk("coin.n11.pend", 32'(pending_cnt), 32'd8);
`ifdef REF_OVERFLOW_FLAG_EN
    goto(10399);
    chk("r3.c10399.ovf", 32'(ref_overflow), 32'd0);
    goto(10400);
    chk("r3.c10400.ovf", 32'(ref_overflow), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
